pulpemu_input_conditioner: RTL and testbench

Synchronises and debounces the board buttons and slide switches before they reach the PULPino SoC top. It produces clean levels for gpio_in, fetch enable and boot select, plus single-cycle rise/fall pulses and a long-press pulse per channel. It sits directly upstream of the emulation top and runs entirely in the 100 MHz board clock domain.

---
 rtl/pulpemu_io_pkg.sv | 24 ++
 rtl/pulpemu_debounce_chan.sv | 114 +++++++++++
 rtl/pulpemu_input_conditioner.sv | 49 ++++
 tb/tb_pulpemu_input_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pulpemu_io_pkg.sv
// pulpemu_io_pkg: shared types, default timing constants and counter-width helper
// for the board input conditioner.  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package pulpemu_io_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_e;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DB_CYCLES   = 1000000;
  localparam int DEFAULT_LONG_CYCLES = 100000000;

  // A counter always needs at least one bit, even for degenerate ranges.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulpemu_debounce_chan.sv
// pulpemu_debounce_chan: one input channel - synchroniser, debounce FSM,
// edge pulses and long-press detection.  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module pulpemu_debounce_chan
  import pulpemu_io_pkg::*;
#(
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int   DB_CYCLES   = DEFAULT_DB_CYCLES,
  parameter int   LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic ext_clk_i,
  input  logic ext_rstn_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic busy_o
);

  localparam int DB_W   = cnt_width(DB_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_d, rise_d, fall_d;
  logic [HOLD_W-1:0]      hold_q;

  assign s      = sync_q[SYNC_STAGES-1];
  assign busy_o = (state_q == CHECK);

  always_ff @(posedge ext_clk_i or negedge ext_rstn_i) begin
    if (!ext_rstn_i) begin
      sync_q   <= {SYNC_STAGES{RST_LEVEL}};
      state_q  <= STABLE;
      db_cnt_q <= '0;
      level_o  <= RST_LEVEL;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_o  <= level_d;
      rise_o   <= rise_d;
      fall_o   <= fall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_o;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      STABLE: begin
        if (s != level_o) begin
          state_d  = CHECK;
          db_cnt_d = DB_ONE;
        end else begin
          db_cnt_d = '0;
        end
      end
      CHECK: begin
        // Any return to the current level is a bounce: restart from scratch.
        if (s == level_o) begin
          state_d  = STABLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          level_d  = s;
          rise_d   = s;
          fall_d   = ~s;
          state_d  = STABLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = STABLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // hold_q saturates at LONG_CYCLES, so long_o fires exactly once per press.
  always_ff @(posedge ext_clk_i or negedge ext_rstn_i) begin
    if (!ext_rstn_i) begin
      hold_q <= '0;
      long_o <= 1'b0;
    end else begin
      long_o <= level_o && (hold_q == HOLD_FIRE);
      if (!level_o) begin
        hold_q <= '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulpemu_input_conditioner.sv
// pulpemu_input_conditioner: debounced levels and event pulses for the board
// buttons and switches, one independent channel per input.  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module pulpemu_input_conditioner
  import pulpemu_io_pkg::*;
#(
  parameter int   N_IN        = 8,
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int   DB_CYCLES   = DEFAULT_DB_CYCLES,
  parameter int   LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic            ext_clk_i,
  input  logic            ext_rstn_i,
  input  logic [N_IN-1:0] raw_i,
  output logic [N_IN-1:0] level_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  output logic [N_IN-1:0] long_o,
  output logic            busy_o
);

  logic [N_IN-1:0] busy_vec;

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    pulpemu_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .RST_LEVEL   (RST_LEVEL)
    ) u_chan (
      .ext_clk_i  (ext_clk_i),
      .ext_rstn_i (ext_rstn_i),
      .raw_i      (raw_i[i]),
      .level_o    (level_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .long_o     (long_o[i]),
      .busy_o     (busy_vec[i])
    );
  end

  assign busy_o = |busy_vec;

endmodule

`default_nettype wire

// File: tb/tb_pulpemu_input_conditioner.sv
// tb_pulpemu_input_conditioner: directed scenarios plus random toggling,
// every output compared each cycle against a behavioural model.
`default_nettype none
`timescale 1ns/1ps

module tb_pulpemu_input_conditioner;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LONG = 10;

  logic         clk;
  logic         rstn;
  logic [N-1:0] raw;
  logic [N-1:0] level_o, rise_o, fall_o, long_o;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int long_cnt2 = 0;

  pulpemu_input_conditioner #(
    .N_IN        (N),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG),
    .RST_LEVEL   (1'b0)
  ) dut (
    .ext_clk_i  (clk),
    .ext_rstn_i (rstn),
    .raw_i      (raw),
    .level_o    (level_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .long_o     (long_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: s is raw delayed by SYNC edges; a new level is accepted
  // after DB consecutive cycles of disagreement; long fires when the high
  // time of the level first reaches LONG cycles.
  logic [SYNC-1:0] m_sync [N];
  int              m_run  [N];
  int              m_hold [N];
  logic [N-1:0]    m_level, m_rise, m_fall, m_long;
  logic            m_busy;
  int              nh;
  logic            ms;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < N; c++) begin
        m_sync[c] = '0;
        m_run[c]  = 0;
        m_hold[c] = 0;
      end
      m_level = '0; m_rise = '0; m_fall = '0; m_long = '0; m_busy = 1'b0;
    end else begin
      m_busy = 1'b0;
      for (int c = 0; c < N; c++) begin
        nh = m_level[c] ? ((m_hold[c] < LONG) ? m_hold[c] + 1 : LONG) : 0;
        m_long[c] = (nh == LONG) && (m_hold[c] != LONG);
        m_hold[c] = nh;
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        ms = m_sync[c][SYNC-1];
        if (ms != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_level[c] = ms;
            m_rise[c]  = ms;
            m_fall[c]  = ~ms;
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_run[c] != 0) m_busy = 1'b1;
        m_sync[c] = {m_sync[c][SYNC-2:0], raw[c]};
      end
    end
  end

  always @(negedge clk) begin
    check("level", 32'(level_o), 32'(m_level));
    check("rise",  32'(rise_o),  32'(m_rise));
    check("fall",  32'(fall_o),  32'(m_fall));
    check("long",  32'(long_o),  32'(m_long));
    check("busy",  32'(busy_o),  32'(m_busy));
    if (rstn && long_o[2]) long_cnt2++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    raw  = 8'hFF;
    wait_neg(4);
    check("rst_level", 32'(level_o), 32'h0);
    check("rst_pulses", 32'(rise_o | fall_o | long_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);

    // Switches already high at release: accepted 5 edges after first sample.
    rstn = 1'b1;
    wait_neg(5);
    check("rel_level_early", 32'(level_o), 32'h0);
    wait_neg(1);
    check("rel_level", 32'(level_o), 32'hFF);
    check("rel_rise", 32'(rise_o), 32'hFF);
    wait_neg(1);
    check("rel_rise_single", 32'(rise_o), 32'h0);

    raw = 8'h00;
    wait_neg(12);

    // Clean press / release on channel 0.
    raw[0] = 1'b1;
    wait_neg(5);
    check("press_early", 32'(level_o[0]), 32'h0);
    wait_neg(1);
    check("press_level", 32'(level_o[0]), 32'h1);
    check("press_rise", 32'(rise_o[0]), 32'h1);
    wait_neg(4);
    raw[0] = 1'b0;
    wait_neg(6);
    check("release_fall", 32'(fall_o[0]), 32'h1);
    check("release_level", 32'(level_o[0]), 32'h0);
    wait_neg(4);

    // Bounce on channel 1: bursts shorter than DB are rejected.
    raw[1] = 1'b1; wait_neg(3);
    check("bounce_busy", 32'(busy_o), 32'h1);
    raw[1] = 1'b0; wait_neg(1);
    raw[1] = 1'b1; wait_neg(3);
    raw[1] = 1'b0; wait_neg(6);
    check("bounce_level", 32'(level_o[1]), 32'h0);
    raw[1] = 1'b1; wait_neg(6);
    check("bounce_accept", 32'(level_o[1]), 32'h1);
    raw[1] = 1'b0; wait_neg(8);

    // Long press on channel 2, twice.
    raw[2] = 1'b1;
    wait_neg(15);
    check("long_early", 32'(long_o[2]), 32'h0);
    wait_neg(1);
    check("long_fire", 32'(long_o[2]), 32'h1);
    wait_neg(4);
    raw[2] = 1'b0;
    wait_neg(10);
    check("long_once", 32'(long_cnt2), 32'd1);
    raw[2] = 1'b1;
    wait_neg(20);
    raw[2] = 1'b0;
    wait_neg(10);
    check("long_again", 32'(long_cnt2), 32'd2);

    // Simultaneous rise on 3 and fall on 4.
    raw[4] = 1'b1;
    wait_neg(8);
    raw[3] = 1'b1;
    raw[4] = 1'b0;
    wait_neg(6);
    check("simul_rise3", 32'(rise_o[3]), 32'h1);
    check("simul_fall4", 32'(fall_o[4]), 32'h1);
    wait_neg(4);

    // Random toggling across all channels.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, N-1)] ^= 1'b1;
      wait_neg(1);
    end

    // Reset two cycles into a debounce of channel 5.
    raw = 8'hFF;
    wait_neg(12);
    raw[5] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midchk_busy", 32'(busy_o), 32'h1);
    #1 rstn = 1'b0;
    #1;
    check("midchk_level", 32'(level_o), 32'h0);
    check("midchk_busy_rst", 32'(busy_o), 32'h0);
    check("midchk_pulses", 32'(rise_o | fall_o | long_o), 32'h0);
    wait_neg(3);
    rstn = 1'b1;
    wait_neg(12);
    check("post_rst_level", 32'(level_o), 32'hDF);

    wait_neg(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
